dma_peripheral_responder: RTL and testbench

Peripheral-side endpoint of the DMA channel handshake: raises DREQ when it has data to send or room to receive, answers DACK-qualified IOR_N/IOW_N strobes on the data bus, and honours EOP_N terminal count. It sits on one DREQ/DACK channel pin pair of the DMA controller and gives local logic a push/pop FIFO interface. It is the bench-side stimulus device for controller verification and the reusable I/O front-end for on-chip DMA clients.

---
 rtl/dma_periph_pkg.sv | 15 +
 rtl/dma_sync_fifo.sv | 58 +++++
 rtl/dma_peripheral_responder.sv | 174 +++++++++++++++++
 tb/tb_dma_peripheral_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_periph_pkg.sv
// Shared types and defaults for the DMA peripheral responder.
// The state enum is the responder's handshake sequence on one DREQ/DACK channel.
package dma_periph_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } dmaState_e;

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock FIFO with occupancy count; push is dropped when full, pop ignored when empty.
// Simultaneous push and pop leave the count unchanged.
module dma_sync_fifo
    import dma_periph_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     gclk,
    input  logic                     grst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wrPtr;
    logic [AW-1:0]     rdPtr;
    logic              doPush;
    logic              doPop;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign dout   = mem[rdPtr];

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge gclk) begin
        if (doPush) mem[wrPtr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dma_peripheral_responder.sv
// Peripheral end of a DREQ/DACK DMA channel: requests service from FIFO state,
// answers DACK-qualified IOR_N/IOW_N strobes, and honours EOP_N terminal count.
module dma_peripheral_responder
    import dma_periph_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET_N,
    output logic              DREQ,
    input  logic              DACK,
    input  logic              IOR_N,
    input  logic              IOW_N,
    input  logic              EOP_N,
    input  logic [DATA_W-1:0] DB_IN,
    output logic [DATA_W-1:0] DB_OUT,
    output logic              DB_OE,
    input  logic              DIR,
    input  logic              DEMAND_MODE,
    input  logic [DATA_W-1:0] txData,
    input  logic              txValid,
    output logic              txReady,
    output logic [DATA_W-1:0] rxData,
    output logic              rxValid,
    input  logic              rxReady,
    output logic              eopSeen,
    input  logic              clearEop,
    output logic              underrun,
    output logic              overrun
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    dmaState_e         state;
    logic [CW-1:0]     txCount, rxCount, txNext, rxNext;
    logic              txFull, txEmpty, rxFull, rxEmpty;
    logic [DATA_W-1:0] txHead, rxCapture;
    logic              rdStrobe, wrStrobe, rdStrobeQ, wrStrobeQ;
    logic              engaged, readDone, writeDone, xferDone;
    logic              txPush, txPop, rxPush, rxPop;
    logic              eopEvent, eopAfter, want, wantAfter;

    // A strobe with both IOR_N and IOW_N low is not a valid cycle and never completes.
    assign rdStrobe  = DACK && !IOR_N && IOW_N;
    assign wrStrobe  = DACK && !IOW_N && IOR_N;
    assign engaged   = (state != IDLE);
    assign readDone  = engaged && !DIR && DACK && rdStrobeQ && IOR_N;
    assign writeDone = engaged &&  DIR && DACK && wrStrobeQ && IOW_N;
    assign xferDone  = readDone || writeDone;

    assign txPush = txValid && !txFull;
    assign txPop  = readDone && !txEmpty;
    assign rxPush = writeDone && !rxFull;
    assign rxPop  = rxReady && !rxEmpty;

    assign txNext = txCount + CW'(txPush) - CW'(txPop);
    assign rxNext = rxCount + CW'(rxPush) - CW'(rxPop);

    assign eopEvent  = DACK && !EOP_N;
    assign eopAfter  = eopSeen || eopEvent;
    assign want      = !eopSeen  && (DIR ? (rxCount != FULL_CNT) : (txCount != '0));
    // Demand mode keeps the channel only if there is still work once this transfer lands.
    assign wantAfter = !eopAfter && (DIR ? (rxNext  != FULL_CNT) : (txNext  != '0));

    assign DB_OE   = engaged && !DIR && rdStrobe;
    assign DB_OUT  = (DB_OE && !txEmpty) ? txHead : '0;
    assign txReady = !txFull;
    assign rxValid = !rxEmpty;

    dma_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) uTxFifo (
        .gclk   (CLK),
        .grst_n (RESET_N),
        .push   (txPush),
        .din    (txData),
        .pop    (txPop),
        .dout   (txHead),
        .full   (txFull),
        .empty  (txEmpty),
        .count  (txCount)
    );

    dma_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) uRxFifo (
        .gclk   (CLK),
        .grst_n (RESET_N),
        .push   (rxPush),
        .din    (rxCapture),
        .pop    (rxPop),
        .dout   (rxData),
        .full   (rxFull),
        .empty  (rxEmpty),
        .count  (rxCount)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rdStrobeQ <= 1'b0;
            wrStrobeQ <= 1'b0;
            rxCapture <= '0;
            eopSeen   <= 1'b0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rdStrobeQ <= rdStrobe;
            wrStrobeQ <= wrStrobe;
            if (wrStrobe) rxCapture <= DB_IN;

            // A fresh terminal count wins over a simultaneous clear.
            if (eopEvent)      eopSeen <= 1'b1;
            else if (clearEop) eopSeen <= 1'b0;

            if (readDone && txEmpty) underrun <= 1'b1;
            else if (clearEop)       underrun <= 1'b0;

            if (writeDone && rxFull) overrun <= 1'b1;
            else if (clearEop)       overrun <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
            DREQ  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (want) begin
                        state <= REQUEST;
                        DREQ  <= 1'b1;
                    end
                end
                REQUEST: begin
                    if (eopEvent) begin
                        state <= RELEASE;
                        DREQ  <= 1'b0;
                    end else if (DACK) begin
                        state <= ACTIVE;
                    end else if (!want) begin
                        state <= IDLE;
                        DREQ  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (xferDone) begin
                        if (!(DEMAND_MODE && wantAfter)) begin
                            state <= RELEASE;
                            DREQ  <= 1'b0;
                        end
                    end else if (!DACK) begin
                        // Preempted before any completion: keep asking unless terminated.
                        if (eopSeen) begin
                            state <= RELEASE;
                            DREQ  <= 1'b0;
                        end else begin
                            state <= REQUEST;
                        end
                    end else if (eopAfter && !rdStrobe && !wrStrobe) begin
                        state <= RELEASE;
                        DREQ  <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (!DACK) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    DREQ  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_peripheral_responder.sv
// Bench for dma_peripheral_responder: directed handshake scenarios, then randomized
// service rounds checked against a queue-based model of the two FIFOs and flags.
module tb_dma_peripheral_responder;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              DREQ;
    logic              DACK = 1'b0;
    logic              IOR_N = 1'b1;
    logic              IOW_N = 1'b1;
    logic              EOP_N = 1'b1;
    logic [DATA_W-1:0] DB_IN = '0;
    logic [DATA_W-1:0] DB_OUT;
    logic              DB_OE;
    logic              DIR = 1'b0;
    logic              DEMAND_MODE = 1'b0;
    logic [DATA_W-1:0] txData = '0;
    logic              txValid = 1'b0;
    logic              txReady;
    logic [DATA_W-1:0] rxData;
    logic              rxValid;
    logic              rxReady = 1'b0;
    logic              eopSeen;
    logic              clearEop = 1'b0;
    logic              underrun;
    logic              overrun;

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO contents as queues plus the three sticky flags.
    logic [7:0] txQ[$];
    logic [7:0] rxQ[$];
    bit         mEop, mUnder, mOver;

    dma_peripheral_responder #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .DACK(DACK),
        .IOR_N(IOR_N), .IOW_N(IOW_N), .EOP_N(EOP_N),
        .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE),
        .DIR(DIR), .DEMAND_MODE(DEMAND_MODE),
        .txData(txData), .txValid(txValid), .txReady(txReady),
        .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady),
        .eopSeen(eopSeen), .clearEop(clearEop),
        .underrun(underrun), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic bit modelWant();
        return !mEop && (DIR ? (rxQ.size() < DEPTH) : (txQ.size() > 0));
    endfunction

    task automatic checkStatus(input string tag);
        chk({tag, " txReady"}, txReady, txQ.size() < DEPTH);
        chk({tag, " rxValid"}, rxValid, rxQ.size() > 0);
        if (rxQ.size() > 0) chk({tag, " rxData"}, rxData, rxQ[0]);
        chk({tag, " eopSeen"}, eopSeen, mEop);
        chk({tag, " underrun"}, underrun, mUnder);
        chk({tag, " overrun"}, overrun, mOver);
    endtask

    task automatic doReset();
        DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1;
        txValid = 1'b0; rxReady = 1'b0; clearEop = 1'b0;
        RESET_N = 1'b0;
        txQ.delete(); rxQ.delete();
        mEop = 1'b0; mUnder = 1'b0; mOver = 1'b0;
        tick(); tick();
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic doClear();
        clearEop = 1'b1;
        tick();
        clearEop = 1'b0;
        mEop = 1'b0; mUnder = 1'b0; mOver = 1'b0;
        checkStatus("clear");
    endtask

    task automatic pushTx(input logic [7:0] b);
        txData = b; txValid = 1'b1;
        tick();
        txValid = 1'b0;
        if (txQ.size() < DEPTH) txQ.push_back(b);
    endtask

    task automatic popRx();
        if (rxQ.size() > 0) chk("pop head", rxData, rxQ[0]);
        rxReady = 1'b1;
        tick();
        rxReady = 1'b0;
        if (rxQ.size() > 0) void'(rxQ.pop_front());
    endtask

    // One two-cycle strobe in the current direction, optionally with EOP_N during the
    // first low cycle and a local push/pop landing on the completion edge.
    // svc says whether the channel is in service, i.e. whether DREQ may stay high.
    task automatic doStrobe(input bit eop, input bit localOp, input logic [7:0] wdata,
                            input bit svc, output bit expDreq);
        logic [7:0] lb;
        int oldN;
        lb = 8'($urandom);
        if (!DIR) IOR_N = 1'b0;
        else begin IOW_N = 1'b0; DB_IN = wdata; end
        EOP_N = !eop;
        tick();
        chk("db_oe", DB_OE, !DIR);
        chk("db_out", DB_OUT, (!DIR && txQ.size() > 0) ? txQ[0] : 8'h00);
        EOP_N = 1'b1;
        tick();
        IOR_N = 1'b1; IOW_N = 1'b1;
        if (localOp) begin
            if (!DIR) begin txData = lb; txValid = 1'b1; end
            else rxReady = 1'b1;
        end
        tick();
        txValid = 1'b0; rxReady = 1'b0;
        if (eop) mEop = 1'b1;
        if (!DIR) begin
            oldN = txQ.size();
            if (oldN == 0) mUnder = 1'b1;
            else void'(txQ.pop_front());
            if (localOp && oldN < DEPTH) txQ.push_back(lb);
        end else begin
            oldN = rxQ.size();
            if (localOp && oldN > 0) void'(rxQ.pop_front());
            if (oldN < DEPTH) rxQ.push_back(wdata);
            else mOver = 1'b1;
        end
        expDreq = svc && DEMAND_MODE && modelWant();
        chk("dreq after xfer", DREQ, expDreq);
        checkStatus("xfer");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit e;
        int n;

        doReset();
        chk("rst dreq", DREQ, 1'b0);
        chk("rst db_oe", DB_OE, 1'b0);
        chk("rst db_out", DB_OUT, 8'h00);
        checkStatus("rst");

        // Read direction, single transfer, then a forced strobe on an empty TX FIFO.
        DIR = 1'b0; DEMAND_MODE = 1'b0;
        pushTx(8'hA5);
        chk("t1 dreq early", DREQ, 1'b0);
        tick();
        chk("t1 dreq", DREQ, 1'b1);
        DACK = 1'b1; tick();
        doStrobe(1'b0, 1'b0, 8'h00, 1'b1, e);
        doStrobe(1'b0, 1'b0, 8'h00, 1'b0, e);
        DACK = 1'b0; tick(); tick();
        chk("t1 idle", DREQ, 1'b0);
        doClear();

        // Demand mode drains three bytes under one request.
        DEMAND_MODE = 1'b1;
        pushTx(8'h01); pushTx(8'h02); pushTx(8'h03);
        tick();
        chk("t2 dreq", DREQ, 1'b1);
        DACK = 1'b1; tick();
        for (int i = 0; i < 3; i++) doStrobe(1'b0, 1'b0, 8'h00, 1'b1, e);
        DACK = 1'b0; tick(); tick();
        chk("t2 idle", DREQ, 1'b0);

        // Write direction: fill to 7, last write fills, extra write overruns.
        doReset();
        DIR = 1'b1; DEMAND_MODE = 1'b0;
        tick();
        chk("t3 dreq", DREQ, 1'b1);
        for (int i = 0; i < 7; i++) begin
            DACK = 1'b1; tick();
            doStrobe(1'b0, 1'b0, 8'($urandom), 1'b1, e);
            DACK = 1'b0; tick(); tick();
            chk("t3 rereq", DREQ, 1'b1);
        end
        DACK = 1'b1; tick();
        doStrobe(1'b0, 1'b0, 8'h3C, 1'b1, e);
        doStrobe(1'b0, 1'b0, 8'hEE, 1'b0, e);
        DACK = 1'b0; tick(); tick();
        chk("t3 full idle", DREQ, 1'b0);
        for (int i = 0; i < DEPTH; i++) popRx();
        checkStatus("t3 drained");

        // Terminal count on the second demand strobe.
        doReset();
        DIR = 1'b0; DEMAND_MODE = 1'b1;
        pushTx(8'h11); pushTx(8'h22); pushTx(8'h33);
        tick();
        chk("t4 dreq", DREQ, 1'b1);
        DACK = 1'b1; tick();
        doStrobe(1'b0, 1'b0, 8'h00, 1'b1, e);
        doStrobe(1'b1, 1'b0, 8'h00, 1'b1, e);
        DACK = 1'b0; tick(); tick(); tick();
        chk("t4 eop hold", DREQ, 1'b0);
        doClear();
        tick();
        chk("t4 after clear", DREQ, 1'b1);
        DACK = 1'b1; tick();
        doStrobe(1'b0, 1'b0, 8'h00, 1'b1, e);
        DACK = 1'b0; tick();

        // Preemption, then asynchronous reset in the middle of a read strobe.
        pushTx(8'h77);
        tick();
        chk("t5 dreq", DREQ, 1'b1);
        DACK = 1'b1; tick();
        DACK = 1'b0; tick();
        chk("t5 preempt dreq", DREQ, 1'b1);
        DACK = 1'b1; tick();
        IOR_N = 1'b0; tick();
        chk("t5 db_oe", DB_OE, 1'b1);
        chk("t5 no pop", DB_OUT, 8'h77);
        #2 RESET_N = 1'b0;
        #1;
        chk("t5 rst dreq", DREQ, 1'b0);
        chk("t5 rst db_oe", DB_OE, 1'b0);
        chk("t5 rst db_out", DB_OUT, 8'h00);
        chk("t5 rst txReady", txReady, 1'b1);
        doReset();

        // Randomized service rounds.
        for (int it = 0; it < 60; it++) begin
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) if (txQ.size() < DEPTH) pushTx(8'($urandom));
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) if (rxQ.size() > 0) popRx();
            tick();
            chk("r dreq", DREQ, modelWant());
            if (modelWant()) begin
                if ($urandom_range(0, 3) == 0) begin
                    DACK = 1'b1; tick();
                    DACK = 1'b0; tick();
                    chk("r preempt", DREQ, 1'b1);
                end
                DACK = 1'b1; tick();
                e = 1'b1; n = 0;
                while (e && n < 6) begin
                    doStrobe($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                             8'($urandom), 1'b1, e);
                    n++;
                end
                DACK = 1'b0; tick();
                if (mEop) doClear();
            end
            if (!modelWant() && $urandom_range(0, 1) == 1) begin
                DIR = 1'($urandom);
                DEMAND_MODE = 1'($urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
